dram_axi_arbiter: RTL and testbench
===================================

# dram_axi_arbiter

Two-requester arbiter and sequencer for the single AXI-lite-style port of the 8192×64-bit DRAM model. It accepts single-beat read/write requests from two clients (the SD↔DRAM bridge on port 0, a secondary client on port 1), grants one at a time, and drives the full AR/R/AW/W/B handshake sequence. It returns read data or write completion to the granted client, with one transaction outstanding at a time.

## Interface
- ADDR_W, 13, DRAM word address width
- DATA_W, 64, DRAM data width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request strobe, held until accepted
- req_write  in  2  1 = write, 0 = read
- req_addr  in  2*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  2*DATA_W  packed write data
- req_ready  out  2  combinational accept: high only in IDLE for the granted requester
- resp_valid  out  2  one-cycle completion pulse to the owning requester
- resp_data  out  DATA_W  read data, valid with resp_valid, 0 otherwise
- resp_err  out  2  R_RESP/B_RESP of the completed transaction
- AR_VALID, AR_ADDR[31:0], R_READY, AW_VALID, AW_ADDR[31:0], W_VALID, W_DATA[63:0], B_READY  out  DRAM master side
- AR_READY, R_VALID, R_DATA[63:0], R_RESP[1:0], AW_READY, W_READY, B_VALID, B_RESP[1:0]  in  DRAM slave side

## Operation
- FSM states: IDLE, AR, R, AW, W, B, RESP.
- IDLE: the grant goes to a requester with req_valid high. Acceptance happens at the edge where req_valid[i] && req_ready[i]. At that edge the block latches the owner, write flag, addr, and wdata. Next state is AR for reads and AW for writes.
- AR: AR_VALID=1, AR_ADDR={19'b0,addr}. When AR_READY is high, go to R.
- R: R_READY=1. When R_VALID is high, capture R_DATA/R_RESP and go to RESP.
- AW: AW_VALID=1, AW_ADDR={19'b0,addr}. When AW_READY is high, go to W. AW and W are never concurrent.
- W: W_VALID=1, W_DATA=wdata. When W_READY is high, go to B.
- B: B_READY=1. When B_VALID is high, capture B_RESP and go to RESP.
- RESP: for one cycle, resp_valid[owner]=1 and resp_data = captured read data (0 for writes). resp_err = captured resp. Then go to IDLE.
- All AXI outputs are registered and are 0 outside their own state. ADDR/W_DATA return to 0 when the corresponding VALID drops.
- Arbitration is round-robin. The pointer toggles to favour the other requester after each acceptance. After reset, requester 0 has priority. With a single requester valid, it is granted regardless of the pointer.
- resp_err passes through non-OKAY codes unchanged. The transaction is not retried.

## Timing
- Reset values: every output is 0 (VALIDs, READYs, ADDRs, W_DATA, resp_*). FSM is IDLE, pointer favours requester 0.
- Reset mid-transaction: the next edge returns to IDLE and drops all VALID/READY. No resp_valid is issued for the aborted transaction.
- Read with zero-wait slave: accept at edge 0; AR_VALID high cycle 1; R_READY high cycle 2; resp_valid cycle 3.
- Write with zero-wait slave: accept at edge 0; AW cycle 1; W cycle 2; B cycle 3; resp_valid cycle 4.
- Slave stalls extend the matching state indefinitely, with no timeout. VALID and payload stay stable while stalled.
- req_ready is 0 in all non-IDLE states, so a new request is accepted at the earliest in the cycle after RESP.
- A requester may drop req_valid before acceptance; the arbiter then re-evaluates in the same cycle.

## Configuration
- DRAM_ARB_FIXED_PRIO_EN defined: fixed priority. Requester 0 always wins when both are valid, and the pointer logic is removed.
- Not defined: round-robin as described in Operation.

## Structure
- Package dram_arb_pkg holds the following:
  - the state enum (IDLE, AR, R, AW, W, B, RESP);
  - the AXI response codes (OKAY=2'b00, SLVERR=2'b10);
  - the ADDR_W/DATA_W defaults;
  - the 32-bit address zero-extension constant.
- Sub-module rr_arbiter2 holds the 2-way grant plus priority pointer, including the fixed-priority variant under the macro. The FSM and datapath stay in the top level.

## Test plan
- Reset check: assert rst for 2 cycles → all outputs read 0 at the following negedge.
- Single read: req0 reads addr 13'h0005 with DRAM[5]=64'h0123_4567_89AB_CDEF, zero-wait slave → AR_ADDR=32'h5, resp_valid=2'b01 three cycles after acceptance, resp_data=64'h0123456789ABCDEF.
- Single write: req1 writes 64'hDEAD_BEEF_CAFE_F00D to addr 13'h1FFF → W_DATA matches, resp_valid=2'b10, resp_err=0, DRAM[8191] updated.
- Contention: both requesters are valid continuously for 4 transactions → grants alternate 0,1,0,1. With DRAM_ARB_FIXED_PRIO_EN the grants are 0,0,0,0.
- Stalls: slave holds AR_READY=0 for 5 cycles and R_VALID=0 for 7 cycles → AR_VALID/AR_ADDR stay stable, resp_valid arrives exactly one cycle after the R handshake.
- Abort: assert rst while in state W → next cycle W_VALID=0, no resp_valid. The next request completes normally.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared state encoding, AXI response codes and width defaults for the DRAM port arbiter.
package dram_arb_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 64;
    localparam int AXI_ADDR_W = 32;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B,
        ST_RESP
    } arb_state_t;

    localparam int ADDR_PAD_W = AXI_ADDR_W - ADDR_W_DEF;
    localparam logic [ADDR_PAD_W-1:0] ADDR_PAD = '0;

    // DRAM word address widened onto the 32-bit AXI address bus
    function automatic logic [AXI_ADDR_W-1:0] zext_addr(input logic [ADDR_W_DEF-1:0] addr);
        return {ADDR_PAD, addr};
    endfunction

endpackage

// File: rtl/dram_axi_arbiter_if.sv
// AXI-lite style single-beat bus between the arbiter (master) and the DRAM model (slave).
interface dram_axi_arbiter_if
    import dram_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic                  AR_VALID;
    logic [AXI_ADDR_W-1:0] AR_ADDR;
    logic                  AR_READY;
    logic                  R_VALID;
    logic [DATA_W-1:0]     R_DATA;
    logic [1:0]            R_RESP;
    logic                  R_READY;
    logic                  AW_VALID;
    logic [AXI_ADDR_W-1:0] AW_ADDR;
    logic                  AW_READY;
    logic                  W_VALID;
    logic [DATA_W-1:0]     W_DATA;
    logic                  W_READY;
    logic                  B_VALID;
    logic [1:0]            B_RESP;
    logic                  B_READY;

    modport master (
        output AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
        input  AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
    );

    modport slave (
        input  AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
        output AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
    );

endinterface

// File: rtl/dram_axi_arbiter_rr_arbiter2.sv
// Two-way grant logic; round-robin by default, fixed priority to requester 0 when
// DRAM_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

`ifdef DRAM_ARB_FIXED_PRIO_EN
    logic w_unused;
    assign w_unused = ^{clk, rst, i_accept};

    always_comb begin
        o_grant = 2'b00;
        if (i_req[0]) begin
            o_grant = 2'b01;
        end else if (i_req[1]) begin
            o_grant = 2'b10;
        end
    end
`else
    // r_ptr = 0 favours requester 0 on contention
    logic r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_accept) begin
            r_ptr <= ~r_ptr;
        end
    end

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end
`endif

endmodule

// File: rtl/dram_axi_arbiter.sv
// Two-requester sequencer for the single DRAM AXI-lite port, one transaction in flight.
// Grant policy: round-robin, or fixed priority when DRAM_ARB_FIXED_PRIO_EN is defined.
module dram_axi_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          i_req_valid,
    input  logic [1:0]          i_req_write,
    input  logic [2*ADDR_W-1:0] i_req_addr,
    input  logic [2*DATA_W-1:0] i_req_wdata,
    output logic [1:0]          o_req_ready,
    output logic [1:0]          o_resp_valid,
    output logic [DATA_W-1:0]   o_resp_data,
    output logic [1:0]          o_resp_err,
    dram_axi_arbiter_if.master  m_axi
);

    arb_state_t            r_state;
    logic                  r_owner;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_ar_valid;
    logic [AXI_ADDR_W-1:0] r_ar_addr;
    logic                  r_r_ready;
    logic                  r_aw_valid;
    logic [AXI_ADDR_W-1:0] r_aw_addr;
    logic                  r_w_valid;
    logic [DATA_W-1:0]     r_w_data;
    logic                  r_b_ready;
    logic [1:0]            r_resp_valid;
    logic [DATA_W-1:0]     r_resp_data;
    logic [1:0]            r_resp_err;

    logic [1:0]            w_grant;
    logic                  w_accept;
    logic                  w_sel;
    logic                  w_sel_write;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [DATA_W-1:0]     w_sel_wdata;
    logic [1:0]            w_owner_onehot;

    rr_arbiter2 u_rr_arbiter2 (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req_valid),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    assign o_req_ready    = (r_state == ST_IDLE) ? w_grant : 2'b00;
    assign w_accept       = |(i_req_valid & o_req_ready);
    assign w_sel          = w_grant[1];
    assign w_sel_write    = w_sel ? i_req_write[1] : i_req_write[0];
    assign w_sel_addr     = w_sel ? i_req_addr[2*ADDR_W-1:ADDR_W] : i_req_addr[ADDR_W-1:0];
    assign w_sel_wdata    = w_sel ? i_req_wdata[2*DATA_W-1:DATA_W] : i_req_wdata[DATA_W-1:0];
    assign w_owner_onehot = r_owner ? 2'b10 : 2'b01;

    // Every bus output is a register that is set on entry to its state and cleared on exit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_wdata      <= '0;
            r_ar_valid   <= 1'b0;
            r_ar_addr    <= '0;
            r_r_ready    <= 1'b0;
            r_aw_valid   <= 1'b0;
            r_aw_addr    <= '0;
            r_w_valid    <= 1'b0;
            r_w_data     <= '0;
            r_b_ready    <= 1'b0;
            r_resp_valid <= 2'b00;
            r_resp_data  <= '0;
            r_resp_err   <= AXI_OKAY;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_sel;
                        r_wdata <= w_sel_wdata;
                        if (w_sel_write) begin
                            r_aw_valid <= 1'b1;
                            r_aw_addr  <= zext_addr(w_sel_addr);
                            r_state    <= ST_AW;
                        end else begin
                            r_ar_valid <= 1'b1;
                            r_ar_addr  <= zext_addr(w_sel_addr);
                            r_state    <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    if (m_axi.AR_READY) begin
                        r_ar_valid <= 1'b0;
                        r_ar_addr  <= '0;
                        r_r_ready  <= 1'b1;
                        r_state    <= ST_R;
                    end
                end
                ST_R: begin
                    if (m_axi.R_VALID) begin
                        r_r_ready    <= 1'b0;
                        r_resp_valid <= w_owner_onehot;
                        r_resp_data  <= m_axi.R_DATA;
                        r_resp_err   <= m_axi.R_RESP;
                        r_state      <= ST_RESP;
                    end
                end
                ST_AW: begin
                    if (m_axi.AW_READY) begin
                        r_aw_valid <= 1'b0;
                        r_aw_addr  <= '0;
                        r_w_valid  <= 1'b1;
                        r_w_data   <= r_wdata;
                        r_state    <= ST_W;
                    end
                end
                ST_W: begin
                    if (m_axi.W_READY) begin
                        r_w_valid <= 1'b0;
                        r_w_data  <= '0;
                        r_b_ready <= 1'b1;
                        r_state   <= ST_B;
                    end
                end
                ST_B: begin
                    if (m_axi.B_VALID) begin
                        r_b_ready    <= 1'b0;
                        r_resp_valid <= w_owner_onehot;
                        r_resp_data  <= '0;
                        r_resp_err   <= m_axi.B_RESP;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_resp_valid <= 2'b00;
                    r_resp_data  <= '0;
                    r_resp_err   <= AXI_OKAY;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_axi.AR_VALID = r_ar_valid;
    assign m_axi.AR_ADDR  = r_ar_addr;
    assign m_axi.R_READY  = r_r_ready;
    assign m_axi.AW_VALID = r_aw_valid;
    assign m_axi.AW_ADDR  = r_aw_addr;
    assign m_axi.W_VALID  = r_w_valid;
    assign m_axi.W_DATA   = r_w_data;
    assign m_axi.B_READY  = r_b_ready;

    assign o_resp_valid = r_resp_valid;
    assign o_resp_data  = r_resp_data;
    assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_dram_axi_arbiter.sv
// Directed and randomized bench for dram_axi_arbiter with a behavioural DRAM slave and
// a reference model of grants, latencies and memory contents; honours DRAM_ARB_FIXED_PRIO_EN.
module tb_dram_axi_arbiter;
    import dram_arb_pkg::*;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 64;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [1:0]          reqValid = 2'b00;
    logic [1:0]          reqWrite = 2'b00;
    logic [2*ADDR_W-1:0] reqAddr = '0;
    logic [2*DATA_W-1:0] reqWdata = '0;
    logic [1:0]          reqReady;
    logic [1:0]          respValid;
    logic [DATA_W-1:0]   respData;
    logic [1:0]          respErr;

    int total = 0;
    int bad = 0;

    int modelPtr = 0;
    logic [63:0] refMem [int];
    bit          pWrite [2];
    logic [12:0] pAddr [2];
    logic [63:0] pData [2];
    logic [1:0]  lastObsGrant;

    int arWait = 0, rWait = 0, awWait = 0, wWait = 0, bWait = 0;
    logic [1:0] rRespCode = AXI_OKAY;
    logic [1:0] bRespCode = AXI_OKAY;

    dram_axi_arbiter_if #(.DATA_W(DATA_W)) axi ();

    dram_axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (reqValid),
        .i_req_write  (reqWrite),
        .i_req_addr   (reqAddr),
        .i_req_wdata  (reqWdata),
        .o_req_ready  (reqReady),
        .o_resp_valid (respValid),
        .o_resp_data  (respData),
        .o_resp_err   (respErr),
        .m_axi        (axi)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] initPattern(input int a);
        if (a == 5) return 64'h0123_4567_89AB_CDEF;
        return {32'(a) * 32'h9E37_79B9, 32'(a) ^ 32'h5A5A_0000};
    endfunction

    function automatic logic [63:0] modelRead(input int a);
        return refMem.exists(a) ? refMem[a] : initPattern(a);
    endfunction

    function automatic int pickGrant(input logic [1:0] v);
        if (v == 2'b11) begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
            return 0;
`else
            return modelPtr;
`endif
        end
        return v[1] ? 1 : 0;
    endfunction

    // Behavioural DRAM slave: updates its handshake inputs on the falling edge
    logic [63:0] dramMem [int];
    int arCnt = 0, rCnt = 0, awCnt = 0, wCnt = 0, bCnt = 0;
    int slvRdAddr = 0, slvWrAddr = 0;

    always @(negedge clk) begin
        axi.AR_READY = 1'b0;
        axi.R_VALID  = 1'b0;
        axi.R_DATA   = '0;
        axi.R_RESP   = 2'b00;
        axi.AW_READY = 1'b0;
        axi.W_READY  = 1'b0;
        axi.B_VALID  = 1'b0;
        axi.B_RESP   = 2'b00;
        if (axi.AR_VALID) begin
            if (arCnt == arWait) begin
                axi.AR_READY = 1'b1;
                slvRdAddr = int'(axi.AR_ADDR[ADDR_W-1:0]);
                arCnt = 0;
            end else arCnt++;
        end else arCnt = 0;
        if (axi.R_READY) begin
            if (rCnt == rWait) begin
                axi.R_VALID = 1'b1;
                axi.R_DATA  = dramMem.exists(slvRdAddr) ? dramMem[slvRdAddr] : initPattern(slvRdAddr);
                axi.R_RESP  = rRespCode;
                rCnt = 0;
            end else rCnt++;
        end else rCnt = 0;
        if (axi.AW_VALID) begin
            if (awCnt == awWait) begin
                axi.AW_READY = 1'b1;
                slvWrAddr = int'(axi.AW_ADDR[ADDR_W-1:0]);
                awCnt = 0;
            end else awCnt++;
        end else awCnt = 0;
        if (axi.W_VALID) begin
            if (wCnt == wWait) begin
                axi.W_READY = 1'b1;
                dramMem[slvWrAddr] = axi.W_DATA;
                wCnt = 0;
            end else wCnt++;
        end else wCnt = 0;
        if (axi.B_READY) begin
            if (bCnt == bWait) begin
                axi.B_VALID = 1'b1;
                axi.B_RESP  = bRespCode;
                bCnt = 0;
            end else bCnt++;
        end else bCnt = 0;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input bit isWrite, input logic [12:0] addr,
                                 input logic [63:0] wdata);
        pWrite[port] = isWrite;
        pAddr[port]  = addr;
        pData[port]  = wdata;
        reqValid[port] = 1'b1;
        reqWrite[port] = isWrite;
        reqAddr[port*ADDR_W +: ADDR_W]  = addr;
        reqWdata[port*DATA_W +: DATA_W] = wdata;
    endtask

    task automatic acceptTxn(output int owner, input string tag);
        int n = 0;
        logic [1:0] expGrant;
        #1;
        while (reqReady == 2'b00 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        owner = pickGrant(reqValid);
        expGrant = (owner == 1) ? 2'b10 : 2'b01;
        lastObsGrant = reqReady;
        checkOutput({tag, "_grant"}, 64'(reqReady), 64'(expGrant));
        @(posedge clk); #1;
        modelPtr = 1 - modelPtr;
    endtask

    task automatic waitResp(input int owner, input bit isWrite, input logic [12:0] addr,
                            input logic [63:0] wdata, input logic [1:0] code, input string tag);
        int cyc = 1;
        int arC = 0, rC = 0, awC = 0, wC = 0, bC = 0;
        int payloadErr = 0;
        int expLat;
        logic [31:0] expAxiAddr;
        logic [63:0] expData;
        logic [39:0] expPhases;
        expAxiAddr = {19'b0, addr};
        expData = isWrite ? 64'h0 : modelRead(int'(addr));
        expLat = isWrite ? 4 + awWait + wWait + bWait : 3 + arWait + rWait;
        expPhases = isWrite ? {8'd0, 8'd0, 8'(1 + awWait), 8'(1 + wWait), 8'(1 + bWait)}
                            : {8'(1 + arWait), 8'(1 + rWait), 8'd0, 8'd0, 8'd0};
        while (respValid == 2'b00 && cyc < 80) begin
            if (axi.AR_VALID) arC++;
            if (axi.R_READY)  rC++;
            if (axi.AW_VALID) awC++;
            if (axi.W_VALID)  wC++;
            if (axi.B_READY)  bC++;
            if (axi.AR_VALID ? (axi.AR_ADDR !== expAxiAddr) : (axi.AR_ADDR !== 32'h0)) payloadErr++;
            if (axi.AW_VALID ? (axi.AW_ADDR !== expAxiAddr) : (axi.AW_ADDR !== 32'h0)) payloadErr++;
            if (axi.W_VALID ? (axi.W_DATA !== wdata) : (axi.W_DATA !== 64'h0)) payloadErr++;
            if ($countones({axi.AR_VALID, axi.R_READY, axi.AW_VALID, axi.W_VALID, axi.B_READY}) > 1)
                payloadErr++;
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput({tag, "_latency"}, 64'(cyc), 64'(expLat));
        checkOutput({tag, "_respValid"}, 64'(respValid), (owner == 1) ? 64'h2 : 64'h1);
        checkOutput({tag, "_respData"}, respData, expData);
        checkOutput({tag, "_respErr"}, 64'(respErr), 64'(code));
        checkOutput({tag, "_phaseCycles"}, 64'({arC[7:0], rC[7:0], awC[7:0], wC[7:0], bC[7:0]}),
                    64'(expPhases));
        checkOutput({tag, "_payload"}, 64'(payloadErr), 64'(0));
        @(posedge clk); #1;
        checkOutput({tag, "_pulseEnd"}, 64'({respValid, respErr}), 64'(0));
        checkOutput({tag, "_dataEnd"}, respData, 64'h0);
        if (isWrite) refMem[int'(addr)] = wdata;
    endtask

    task automatic runTxn(input int port, input bit isWrite, input logic [12:0] addr,
                          input logic [63:0] wdata, input logic [1:0] code, input string tag);
        int owner;
        rRespCode = code;
        bRespCode = code;
        applyStimulus(port, isWrite, addr, wdata);
        acceptTxn(owner, tag);
        reqValid = 2'b00;
        waitResp(owner, isWrite, addr, wdata, code, tag);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int owner;
        int n;
        int fav;
        logic [7:0] obsSeq;
        logic [7:0] expSeq;
        bit tw;
        logic [12:0] ta;
        logic [63:0] td;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_resp", 64'({respValid, respErr, reqReady}), 64'(0));
        checkOutput("rst_respData", respData, 64'h0);
        checkOutput("rst_axiCtl", 64'({axi.AR_VALID, axi.R_READY, axi.AW_VALID, axi.W_VALID, axi.B_READY}), 64'(0));
        checkOutput("rst_arAddr", 64'(axi.AR_ADDR), 64'(0));
        checkOutput("rst_awAddr", 64'(axi.AW_ADDR), 64'(0));
        checkOutput("rst_wData", axi.W_DATA, 64'h0);
        rst = 1'b0;

        runTxn(0, 1'b0, 13'h0005, 64'h0, AXI_OKAY, "read0");
        runTxn(1, 1'b1, 13'h1FFF, 64'hDEAD_BEEF_CAFE_F00D, AXI_OKAY, "write1");
        checkOutput("dram8191", dramMem.exists(8191) ? dramMem[8191] : 64'h0, 64'hDEAD_BEEF_CAFE_F00D);

        // withdrawal before acceptance: grant follows the remaining requester in the same cycle
        applyStimulus(0, 1'b0, 13'h0020, 64'h0);
        applyStimulus(1, 1'b0, 13'h0021, 64'h0);
        #1;
        fav = pickGrant(2'b11);
        checkOutput("drop_both", 64'(reqReady), (fav == 1) ? 64'h2 : 64'h1);
        reqValid[fav] = 1'b0;
        #1;
        checkOutput("drop_other", 64'(reqReady), (fav == 1) ? 64'h1 : 64'h2);
        reqValid = 2'b00;
        #1;
        checkOutput("drop_none", 64'(reqReady), 64'(0));
        @(posedge clk); #1;

        arWait = 5;
        rWait = 7;
        runTxn(0, 1'b0, 13'($urandom_range(0, 8191)), 64'h0, AXI_OKAY, "stall");
        arWait = 0;
        rWait = 0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        modelPtr = 0;
        rRespCode = AXI_OKAY;
        bRespCode = AXI_OKAY;
        obsSeq = '0;
        applyStimulus(0, 1'b0, 13'h0010, 64'h0);
        applyStimulus(1, 1'b1, 13'h0011, {$urandom, $urandom});
        for (int k = 0; k < 4; k++) begin
            acceptTxn(owner, "contend");
            obsSeq = {obsSeq[5:0], lastObsGrant};
            tw = pWrite[owner];
            ta = pAddr[owner];
            td = pData[owner];
            if (k == 3) reqValid = 2'b00;
            else applyStimulus(owner, 1'(k % 2), 13'($urandom_range(16, 31)), {$urandom, $urandom});
            waitResp(owner, tw, ta, td, AXI_OKAY, "contend");
        end
`ifdef DRAM_ARB_FIXED_PRIO_EN
        expSeq = 8'b01_01_01_01;
`else
        expSeq = 8'b01_10_01_10;
`endif
        checkOutput("contend_seq", 64'(obsSeq), 64'(expSeq));

        for (int k = 0; k < 8; k++) begin
            arWait = $urandom_range(0, 3);
            rWait  = $urandom_range(0, 3);
            awWait = $urandom_range(0, 3);
            wWait  = $urandom_range(0, 3);
            bWait  = $urandom_range(0, 3);
            runTxn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 13'($urandom_range(0, 7)),
                   {$urandom, $urandom}, ($urandom_range(0, 1) != 0) ? AXI_SLVERR : AXI_OKAY, "rand");
        end
        arWait = 0; rWait = 0; awWait = 0; wWait = 0; bWait = 0;
        rRespCode = AXI_OKAY;
        bRespCode = AXI_OKAY;

        applyStimulus(0, 1'b1, 13'h0ABC, {$urandom, $urandom});
        wWait = 4;
        acceptTxn(owner, "abort");
        reqValid = 2'b00;
        n = 0;
        while (!axi.W_VALID && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("abort_inW", 64'(axi.W_VALID), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_ctl", 64'({axi.W_VALID, axi.B_READY, axi.AW_VALID}), 64'(0));
        checkOutput("abort_wData", axi.W_DATA, 64'h0);
        rst = 1'b0;
        modelPtr = 0;
        wWait = 0;
        n = 0;
        repeat (6) begin
            if (respValid != 2'b00) n++;
            @(posedge clk); #1;
        end
        checkOutput("abort_noResp", 64'(n), 64'(0));
        runTxn(1, 1'b0, 13'h0ABC, 64'h0, AXI_OKAY, "postAbort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
